grid_clb_param: RTL and testbench
=================================

// Module: grid_clb_param
// PURPOSE
// - Parametrised CLB tile: NUM_BLE logic elements (K-input LUT + FF), config held in an in-tile ccff shift chain.
// - Single-clock configuration load, bit-count/done tracking, shift-register chain (regin/regout) and scan chain (scin/scout).
// - Sits in the fabric grid between routing switch blocks. Outputs are isolated (forced 0) until configuration completes.
// PARAMETERS
// - NUM_BLE  8  number of logic elements
// - LUT_K    4  LUT inputs per BLE; LUT table = 2**LUT_K bits
// - Derived: W = 2**LUT_K + 3 config bits per BLE; CFG_LEN = NUM_BLE*W (+1 with parity macro)
// PORTS
// - clk        in   1              single clock, rising edge
// - reset      in   1              asynchronous, active-high
// - set        in   1              sync, loads every FF with its INIT config bit
// - Test_en    in   1              scan-shift mode for the user FFs
// - ccff_en    in   1              config shift enable
// - ccff_head  in   1              config serial in
// - clb_I      in   NUM_BLE*LUT_K  BLE i uses clb_I[i*LUT_K +: LUT_K]
// - clb_regin  in   1              chain input to BLE0 FF
// - clb_scin   in   1              scan input to BLE0 FF
// - clb_O      out  NUM_BLE        BLE outputs
// - clb_regout out  1              q[NUM_BLE-1]
// - clb_scout  out  1              q[NUM_BLE-1]
// - ccff_tail  out  1              cfg[CFG_LEN-1]
// - cfg_done   out  1              exactly CFG_LEN bits shifted since reset
// - cfg_err    out  1              parity error (macro only; else 0)
// BEHAVIOUR
// - Reset: cfg[] = 0, q[] = 0, shift counter = 0; cfg_done/cfg_err/clb_O/ccff_tail/clb_regout/clb_scout = 0.
// - Config shift (ccff_en=1): cfg <= {cfg[CFG_LEN-2:0], ccff_head}. First bit in ends at MSB. ccff_tail lags head by CFG_LEN cycles.
// - Field BLE i = cfg[i*W +: W]: [2**K-1:0] truth table indexed by inputs; [2**K] OUTSEL (1 = registered);
//   [2**K+1] DSEL (1 = chain input); [2**K+2] INIT.
// - Counter: +1 per ccff_en cycle, saturates at CFG_LEN. cfg_done registered, =1 when count==CFG_LEN; stays 1 on further shifts.
// - lut[i] = table_i[clb_I slice]; comb path; 0 cycle latency.
// - d[i] = DSEL ? (i==0 ? clb_regin : q[i-1]) : lut[i]
// - clb_O[i] = cfg_done ? (OUTSEL ? q[i] : lut[i]) : 0. Registered path has 1-cycle latency.
// - FF priority per edge: Test_en (q[0]<=clb_scin, q[i]<=q[i-1]) > ccff_en (hold) > set (q[i]<=INIT_i) > normal (q[i]<=d[i]).
// - Config shift runs independently of FF mode. Test_en with ccff_en: both act in the same cycle.
// - Reset mid-load: counter and cfg clear immediately. A full CFG_LEN reload is required.
// - NUM_BLE=1: chain/scan degenerate to a single FF. Regout and scout always mirror the last FF.
// CONFIGURATION
// - GRID_CLB_CFG_PARITY_EN defined: chain gains one parity bit at cfg[CFG_LEN-1] (CFG_LEN = NUM_BLE*W+1).
//   On the cycle cfg_done rises, cfg_err <= ^cfg (odd total = error). cfg_err is sticky until reset, and clb_O stays 0 while cfg_err=1.
// - Undefined: no parity bit; cfg_err constant 0; CFG_LEN = NUM_BLE*W.
// TESTING (NUM_BLE=2, LUT_K=2, W=7, CFG_LEN=14, macro off unless stated)
// - Reset, shift 13 bits -> cfg_done=0, clb_O=0. 14th bit -> cfg_done=1 next cycle. Extra shifts keep cfg_done=1.
// - Load both BLEs as AND, comb (table 4'b1000, OUTSEL=0). Drive clb_I=4'b0011 -> clb_O=2'b01 same cycle. 4'b1111 -> 2'b11.
// - BLE0/1 DSEL=1, OUTSEL=1. Pulse clb_regin=1 for one cycle -> clb_O[0]=1 at +1, clb_O[1]/clb_regout=1 at +2.
// - INIT=1/0, set=1 -> q=2'b01. Test_en=1, scin 1,0 -> scout follows q[1] one cycle per shift. Assert ccff_en -> q holds.
// - Assert reset after 7 config bits, release, shift 14 -> cfg_done only after 14 post-reset shifts. ccff_tail echoes head 14 cycles late.
// - Macro on, CFG_LEN=15: even-parity stream -> cfg_err=0. Flip one bit -> cfg_err=1 sticky, clb_O=0.

Source files
------------

// File: rtl/grid_clb_param.sv
// -----------------------------------------------------------------------------
// grid_clb_param
//
// Parametrised configurable logic block tile. NUM_BLE basic logic elements,
// each a LUT_K-input LUT followed by a flip-flop. All per-BLE configuration is
// held in an in-tile serial shift chain (ccff_head -> ccff_tail). The tile
// keeps its outputs at 0 until a complete configuration image has been shifted
// in since the last reset.
//
// Per-BLE configuration field (W = 2**LUT_K + 3 bits, BLE i at cfg[i*W +: W]):
//   [2**K-1:0] truth table, indexed by the BLE's input slice
//   [2**K]     OUTSEL  1 = drive clb_O from the flip-flop, 0 = from the LUT
//   [2**K+1]   DSEL    1 = FF D comes from the chain (clb_regin / previous FF)
//   [2**K+2]   INIT    value loaded into the FF by 'set'
//
// Optional feature macro: GRID_CLB_CFG_PARITY_EN
//   When defined, one extra parity bit sits at the top of the chain. The
//   whole image must have even parity; otherwise cfg_err latches high on the
//   cycle cfg_done rises and stays high until reset, keeping clb_O at 0.
//   When undefined, cfg_err is constant 0 and there is no parity bit.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   set         in   synchronous load of each FF with its INIT bit
//   Test_en     in   scan-shift mode for the user FFs (highest priority)
//   ccff_en     in   configuration shift enable (FFs hold unless scanning)
//   ccff_head   in   configuration serial input
//   clb_I       in   LUT inputs, BLE i uses clb_I[i*LUT_K +: LUT_K]
//   clb_regin   in   register-chain input to BLE0's FF
//   clb_scin    in   scan input to BLE0's FF
//   clb_O       out  BLE outputs (0 until configured)
//   clb_regout  out  last FF of the register chain
//   clb_scout   out  last FF of the scan chain (same FF as clb_regout)
//   ccff_tail   out  configuration serial output (top bit of the chain)
//   cfg_done    out  a full image has been shifted in since reset
//   cfg_err     out  parity error flag (parity build only)
// -----------------------------------------------------------------------------
module grid_clb_param #(
    parameter int NUM_BLE = 8,
    parameter int LUT_K   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set,
    input  logic                       Test_en,
    input  logic                       ccff_en,
    input  logic                       ccff_head,
    input  logic [NUM_BLE*LUT_K-1:0]   clb_I,
    input  logic                       clb_regin,
    input  logic                       clb_scin,
    output logic [NUM_BLE-1:0]         clb_O,
    output logic                       clb_regout,
    output logic                       clb_scout,
    output logic                       ccff_tail,
    output logic                       cfg_done,
    output logic                       cfg_err
);

    localparam int TBL = 2 ** LUT_K;
    localparam int W   = TBL + 3;
`ifdef GRID_CLB_CFG_PARITY_EN
    localparam int CFG_LEN = NUM_BLE * W + 1;
`else
    localparam int CFG_LEN = NUM_BLE * W;
`endif
    localparam int CNT_W = $clog2(CFG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);

    // Configuration chain, bit counter and status flags
    logic [CFG_LEN-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // User flip-flops, one per BLE
    logic [NUM_BLE-1:0] q_q, q_d;

    // Outputs are released only once configured and (if checked) error-free
    logic               out_en;

    // ------------------------------------------------------------------
    // Configuration shift and load tracking
    // ------------------------------------------------------------------
    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        if (ccff_en) begin
            cfg_d = {cfg_q[CFG_LEN-2:0], ccff_head};
            // Counter saturates so cfg_done stays set on further shifts
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Done is registered alongside the count so it asserts on the same
        // edge that captures the last configuration bit.
        done_d = (cnt_d == CNT_FULL);
    end

`ifdef GRID_CLB_CFG_PARITY_EN
    // Parity is judged once, on the image present at the edge where done
    // rises; after that the flag is sticky.
    always_comb begin
        err_d = err_q;
        if (done_d && !done_q && (^cfg_d)) begin
            err_d = 1'b1;
        end
    end
`else
    always_comb begin
        err_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign out_en = done_q & ~err_q;

    // ------------------------------------------------------------------
    // Logic elements
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BLE; gi++) begin : g_ble
        logic [TBL-1:0] tbl;
        logic           outsel;
        logic           dsel;
        logic           init;
        logic           lut;
        logic           chain_in;
        logic           scan_in;
        logic           d;

        assign tbl    = cfg_q[gi*W +: TBL];
        assign outsel = cfg_q[gi*W + TBL];
        assign dsel   = cfg_q[gi*W + TBL + 1];
        assign init   = cfg_q[gi*W + TBL + 2];

        // Combinational LUT: the input slice addresses the truth table
        assign lut = tbl[clb_I[gi*LUT_K +: LUT_K]];

        // BLE0 is fed from the tile inputs; later BLEs from their neighbour
        if (gi == 0) begin : g_first
            assign chain_in = clb_regin;
            assign scan_in  = clb_scin;
        end else begin : g_rest
            assign chain_in = q_q[gi-1];
            assign scan_in  = q_q[gi-1];
        end

        assign d = dsel ? chain_in : lut;

        // Scan beats a config shift (which freezes the FFs), which beats set
        assign q_d[gi] = Test_en ? scan_in  :
                         ccff_en ? q_q[gi]  :
                         set     ? init     :
                                   d;

        assign clb_O[gi] = out_en ? (outsel ? q_q[gi] : lut) : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign clb_regout = q_q[NUM_BLE-1];
    assign clb_scout  = q_q[NUM_BLE-1];
    assign ccff_tail  = cfg_q[CFG_LEN-1];
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_grid_clb_param.sv
// -----------------------------------------------------------------------------
// tb_grid_clb_param
//
// Bench for a 2-BLE, 2-input tile. Directed scenarios for load tracking,
// combinational and registered paths, set/scan/hold priority, reset during a
// load and (parity build) the error flag, followed by randomized traffic.
// A reference model tracks the tile as "the last CFG_LEN bits shifted since
// reset" plus one value per user FF, and every cycle all outputs are compared
// against it.
// -----------------------------------------------------------------------------
module tb_grid_clb_param;

    localparam int NB = 2;
    localparam int K  = 2;
    localparam int T  = 4;
    localparam int W  = T + 3;
`ifdef GRID_CLB_CFG_PARITY_EN
    localparam int CFG_LEN = NB * W + 1;
`else
    localparam int CFG_LEN = NB * W;
`endif

    logic              clk;
    logic              reset;
    logic              set;
    logic              Test_en;
    logic              ccff_en;
    logic              ccff_head;
    logic [NB*K-1:0]   clb_I;
    logic              clb_regin;
    logic              clb_scin;
    logic [NB-1:0]     clb_O;
    logic              clb_regout;
    logic              clb_scout;
    logic              ccff_tail;
    logic              cfg_done;
    logic              cfg_err;

    int checks   = 0;
    int failures = 0;

    grid_clb_param #(
        .NUM_BLE (NB),
        .LUT_K   (K)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .set        (set),
        .Test_en    (Test_en),
        .ccff_en    (ccff_en),
        .ccff_head  (ccff_head),
        .clb_I      (clb_I),
        .clb_regin  (clb_regin),
        .clb_scin   (clb_scin),
        .clb_O      (clb_O),
        .clb_regout (clb_regout),
        .clb_scout  (clb_scout),
        .ccff_tail  (ccff_tail),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit m_hist[$];   // bits shifted since reset, oldest first, at most CFG_LEN
    bit m_q[NB];
    bit m_err;

    // cfg bit j holds the bit shifted in j shifts ago
    function automatic bit mcfg(input int j);
        if (j < m_hist.size()) return m_hist[m_hist.size() - 1 - j];
        return 1'b0;
    endfunction

    function automatic bit mdone();
        return m_hist.size() == CFG_LEN;
    endfunction

    function automatic bit mlut(input int i);
        int idx;
        idx = int'(clb_I[i*K +: K]);
        return mcfg(i*W + idx);
    endfunction

    function automatic logic [NB-1:0] exp_O();
        logic [NB-1:0] o;
        o = '0;
        for (int i = 0; i < NB; i++) begin
            if (mdone() && !m_err) begin
                o[i] = mcfg(i*W + T) ? m_q[i] : mlut(i);
            end
        end
        return o;
    endfunction

    task automatic model_step();
        bit nq[NB];
        bit prev;
        bit was_done;
        int ones;
        for (int i = 0; i < NB; i++) begin
            if (Test_en) begin
                nq[i] = (i == 0) ? clb_scin : m_q[i-1];
            end else if (ccff_en) begin
                nq[i] = m_q[i];
            end else if (set) begin
                nq[i] = mcfg(i*W + T + 2);
            end else begin
                prev  = (i == 0) ? clb_regin : m_q[i-1];
                nq[i] = mcfg(i*W + T + 1) ? prev : mlut(i);
            end
        end
        if (ccff_en) begin
            was_done = mdone();
            m_hist.push_back(ccff_head);
            if (m_hist.size() > CFG_LEN) void'(m_hist.pop_front());
`ifdef GRID_CLB_CFG_PARITY_EN
            if (!was_done && mdone()) begin
                ones = 0;
                foreach (m_hist[n]) ones += int'(m_hist[n]);
                if (ones % 2 == 1) m_err = 1'b1;
            end
`else
            ones = 0;
`endif
        end
        for (int i = 0; i < NB; i++) m_q[i] = nq[i];
    endtask

    task automatic check_all();
        chk("clb_O",      clb_O,      exp_O());
        chk("cfg_done",   cfg_done,   mdone());
        chk("ccff_tail",  ccff_tail,  mcfg(CFG_LEN - 1));
        chk("clb_regout", clb_regout, m_q[NB-1]);
        chk("clb_scout",  clb_scout,  m_q[NB-1]);
        chk("cfg_err",    cfg_err,    m_err);
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (called at the falling edge, inputs already set)
    // ------------------------------------------------------------------
    task automatic cycle();
        #2;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        ccff_en = 1'b0;
        Test_en = 1'b0;
        set     = 1'b0;
        m_hist.delete();
        for (int i = 0; i < NB; i++) m_q[i] = 1'b0;
        m_err = 1'b0;
        #2;
        chk("rst_O",      clb_O,      0);
        chk("rst_done",   cfg_done,   0);
        chk("rst_tail",   ccff_tail,  0);
        chk("rst_regout", clb_regout, 0);
        chk("rst_scout",  clb_scout,  0);
        chk("rst_err",    cfg_err,    0);
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset");
    endtask

    task automatic shift1(input logic b);
        ccff_en   = 1'b1;
        ccff_head = b;
        cycle();
        ccff_en   = 1'b0;
    endtask

    // Shifts the first n bits of v, most significant bit first
    task automatic shift_bits(input logic [CFG_LEN-1:0] v, input int n);
        for (int k = 0; k < n; k++) shift1(v[CFG_LEN-1-k]);
        $display("txn shift n=%0d word=%h done=%b", n, v, cfg_done);
    endtask

    // Field layout per BLE: {INIT, DSEL, OUTSEL, table[3:0]}
    function automatic logic [CFG_LEN-1:0] mk_cfg(input logic [6:0] f0, input logic [6:0] f1);
        logic [CFG_LEN-1:0] v;
        v = '0;
        v[6:0]  = f0;
        v[13:7] = f1;
`ifdef GRID_CLB_CFG_PARITY_EN
        v[14]   = ^{f1, f0};
`endif
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [CFG_LEN-1:0] w;
        reset = 1'b1; set = 1'b0; Test_en = 1'b0; ccff_en = 1'b0;
        ccff_head = 1'b0; clb_I = '0; clb_regin = 1'b0; clb_scin = 1'b0;
        @(negedge clk);
        do_reset();

        // Load tracking and combinational AND in both BLEs
        w = mk_cfg(7'b0001000, 7'b0001000);
        clb_I = 4'b1111;
        shift_bits(w, CFG_LEN - 1);
        chk("done_pre", cfg_done, 0);
        chk("O_pre",    clb_O,    0);
        shift1(w[0]);
        chk("done_full", cfg_done, 1);
        clb_I = 4'b0011; #1;
        chk("and_0011", clb_O, 2'b01);
        cycle();
        clb_I = 4'b1111; #1;
        chk("and_1111", clb_O, 2'b11);
        cycle();
        clb_I = 4'b1101; #1;
        chk("and_1101", clb_O, 2'b10);
        cycle();
        clb_I = 4'b0000;
        shift1(1'b0);
        chk("done_extra", cfg_done, 1);

        // Register chain: DSEL=1, OUTSEL=1 in both BLEs
        w = mk_cfg(7'b0110000, 7'b0110000);
        shift_bits(w, CFG_LEN);
        set = 1'b1; cycle(); set = 1'b0;
        chk("chain0_O", clb_O, 2'b00);
        clb_regin = 1'b1; cycle(); clb_regin = 1'b0;
        chk("chain1_O",      clb_O,      2'b01);
        chk("chain1_regout", clb_regout, 0);
        cycle();
        chk("chain2_O",      clb_O,      2'b10);
        chk("chain2_regout", clb_regout, 1);
        cycle();
        chk("chain3_O", clb_O, 2'b00);

        // Set, scan and hold: INIT0=1, INIT1=0, OUTSEL=1
        w = mk_cfg(7'b1010000, 7'b0010000);
        shift_bits(w, CFG_LEN);
        set = 1'b1; cycle(); set = 1'b0;
        chk("set_O",     clb_O,     2'b01);
        chk("set_scout", clb_scout, 0);
        Test_en = 1'b1;
        clb_scin = 1'b1; cycle();
        chk("scan1_scout", clb_scout, 1);
        chk("scan1_O",     clb_O,     2'b11);
        clb_scin = 1'b0; cycle();
        chk("scan2_scout", clb_scout, 1);
        cycle();
        chk("scan3_scout", clb_scout, 0);
        clb_scin = 1'b1; cycle(); cycle();
        Test_en = 1'b0; set = 1'b1;
        shift1(1'b0);
        set = 1'b0;
        chk("hold_regout", clb_regout, 1);
        chk("hold_scout",  clb_scout,  1);

        // Reset in the middle of a load
        do_reset();
        w = CFG_LEN'($urandom);
        shift_bits(w, 7);
        do_reset();
        shift_bits(w, CFG_LEN - 1);
        chk("mid_done_pre", cfg_done, 0);
        shift1(w[0]);
        chk("mid_done", cfg_done, 1);
        chk("tail_echo", ccff_tail, w[CFG_LEN-1]);

`ifdef GRID_CLB_CFG_PARITY_EN
        do_reset();
        w = mk_cfg(7'($urandom), 7'($urandom));
        shift_bits(w, CFG_LEN);
        chk("par_ok", cfg_err, 0);
        do_reset();
        w[3] = ~w[3];
        shift_bits(w, CFG_LEN);
        chk("par_err", cfg_err, 1);
        clb_I = 4'b1111; #1;
        chk("par_err_O", clb_O, 0);
        shift1(1'b1);
        chk("par_sticky", cfg_err, 1);
`endif

        // Randomized traffic with occasional resets and full reloads
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 59) == 0) begin
                w = CFG_LEN'($urandom);
`ifdef GRID_CLB_CFG_PARITY_EN
                if ($urandom_range(0, 1) == 0) w[CFG_LEN-1] = ^w[CFG_LEN-2:0];
`endif
                shift_bits(w, CFG_LEN);
            end else begin
                ccff_en   = ($urandom_range(0, 3) == 0);
                Test_en   = ($urandom_range(0, 7) == 0);
                set       = ($urandom_range(0, 7) == 0);
                ccff_head = 1'($urandom);
                clb_I     = (NB*K)'($urandom);
                clb_regin = 1'($urandom);
                clb_scin  = 1'($urandom);
                cycle();
                $display("txn %0d en=%b te=%b set=%b I=%h O=%b done=%b err=%b",
                         n, ccff_en, Test_en, set, clb_I, clb_O, cfg_done, cfg_err);
                ccff_en = 1'b0; Test_en = 1'b0; set = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
